// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline-stage register with optional 2-entry skid buffer, flush and bubble counter
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 26,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              in_CLK,
    input  logic              in_CLR_n,
    input  logic              in_EN,
    input  logic              in_flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_control,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_control,
    output logic [CNT_W-1:0]  out_bubbles
);
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [CNT_W-1:0]  bubbles;
    logic              accept, consume;

    // with SKID the ready comes from registered state only, cutting the out_ready -> in_ready path
    assign in_ready    = in_CLR_n & in_EN & (SKID != 0 ? ~skid_valid : (~main_valid | out_ready));
    assign out_valid   = main_valid & in_EN;
    assign out_data    = main_data;
    assign out_control = main_valid ? main_ctrl : '0;
    assign out_bubbles = bubbles;
    assign accept      = in_valid & in_ready;
    assign consume     = out_valid & out_ready;

    always_ff @(posedge in_CLK or negedge in_CLR_n) begin
        if (!in_CLR_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            bubbles    <= '0;
        end else if (in_EN) begin
            if (!main_valid && bubbles != {CNT_W{1'b1}})
                bubbles <= bubbles + 1'b1;
            if (in_flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (consume) begin
                    main_data  <= skid_data;
                    main_ctrl  <= skid_ctrl;
                    skid_valid <= 1'b0;
                end
            end else if (accept && (!main_valid || consume)) begin
                main_data  <= in_data;
                main_ctrl  <= in_control;
                main_valid <= 1'b1;
            end else if (accept && SKID != 0) begin
                skid_data  <= in_data;
                skid_ctrl  <= in_control;
                skid_valid <= 1'b1;
            end else if (consume) begin
                main_valid <= 1'b0;
            end
        end
    end
endmodule
